rfphoenix_insn_queue: RTL and testbench
=======================================

// Module: rfphoenix_insn_queue
// PURPOSE
//  Instruction queue between fetch and rfPhoenix_decoder. Buffers fetched words and pairs each
//  instruction with an immediately following postfix (PFX) word. Presents {ir, pfx} to the decoder
//  with a valid/ready handshake. Discards orphan postfixes and never issues a postfix as an instruction.
// PARAMETERS
//  DEPTH    8                   queue entries; power of two, >=4
//  INSN_W   40                  instruction word width
//  OPC_W    7                   opcode field width; field sits at bits [OPC_W-1:0]
//  PFX_OPC  rfPhoenixPkg::PFX   opcode value identifying a postfix word
//  LA_TMO   4                   cycles a lone head instruction waits for lookahead before issuing alone
// PORTS
//  clk_i      in   1        clock
//  rst_ni     in   1        asynchronous reset, active low
//  flush_i    in   1        synchronous flush (branch/exception redirect)
//  fv_i       in   1        fetch word valid
//  fword_i    in   INSN_W   fetched word
//  fready_o   out  1        queue accepts a word this cycle
//  dv_o       out  1        decoder pair valid
//  ir_o       out  INSN_W   instruction to decoder
//  pfx_o      out  INSN_W   postfix to decoder; all-zero when no postfix is attached
//  dready_i   in   1        decoder accepts pair
//  orphan_o   out  1        one-cycle pulse: orphan postfix discarded
// BEHAVIOUR
//  - Reset (rst_ni low, async): rd/wr pointers=0, count=0, tmo counter=0, dv_o=0, ir_o=0, pfx_o=0,
//    orphan_o=0, fready_o=0 while asserted; fready_o=1 from the first cycle after release.
//  - Storage: circular buffer, log2(DEPTH)-bit pointers wrap DEPTH-1 -> 0; count is log2(DEPTH)+1 bits.
//  - Push: fv_i & fready_o writes fword_i at wr_ptr. fready_o = (count < DEPTH), registered.
//    A word offered while fready_o=0 is not taken; fetch holds it.
//  - Head classification: H = entry[rd_ptr], N = entry[rd_ptr+1].
//    isPfx(w) = (w[OPC_W-1:0] == PFX_OPC).
//  - Output state (combinational from registered queue state, zero-latency to decoder):
//    * count>=1 & isPfx(H): orphan. Pop 1 unconditionally; orphan_o=1 that cycle; dv_o=0.
//    * count>=2 & !isPfx(H) & isPfx(N): dv_o=1, ir_o=H, pfx_o=N; handshake pops 2.
//    * count>=2 & !isPfx(H) & !isPfx(N): dv_o=1, ir_o=H, pfx_o=0; handshake pops 1.
//    * count==1 & !isPfx(H): dv_o=1 only once tmo==LA_TMO; pfx_o=0; handshake pops 1.
//    * count==0: dv_o=0. ir_o and pfx_o are don't-care but are driven 0.
//  - tmo counter: increments while count==1 and head is not a postfix, saturating at LA_TMO.
//    Clears on any pop, on flush, or when count!=1.
//    Whenever dv_o=0, ir_o/pfx_o are driven to 0.
//  - Handshake: pop occurs on dv_o & dready_i. dv_o, ir_o and pfx_o are held stable while dready_i=0,
//    except when a lookahead arrives during a count==1 timeout issue. That case is legal and
//    switches to the pair form only if the timeout had not been reached.
//  - Simultaneous push and pop (1 or 2) in one cycle: count_next = count + push - popn.
//    A full queue accepts no push, even with a concurrent pop (registered fready_o).
//  - Flush: pointers, count and tmo -> 0 next cycle; any same-cycle push and pop are ignored;
//    dv_o=0 in the following cycle. Flush has priority over everything except reset.
//  - Reset mid-operation: all contents are lost; there is no partial pop.
// CONFIGURATION
//  RFPHX_IQ_STATS_EN defined:
//    Adds outputs stat_issued_o[31:0], stat_fused_o[31:0] and stat_orphan_o[15:0].
//    These count handshakes, pair handshakes and orphan discards, wrap on overflow,
//    clear on reset only (not on flush).
//  Undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1 Push A(ADD), B(ADD), dready_i=1 -> ir_o=A,pfx_o=0 then ir_o=B (after LA_TMO=4 wait), count->0.
//  2 Push A(ADDI), P(PFX imm=16'h1234), dready_i=1 -> single handshake ir_o=A, pfx_o=P, count 2->0.
//  3 Reset, push P alone -> orphan_o pulses once, dv_o stays 0, count=0; stat_orphan_o=1 if STATS_EN.
//  4 Push 8 words with dready_i=0 -> fready_o=0 at count=8. Raise dready_i and push the same cycle:
//    push is refused, and the pointer wraps 7->0 correctly on subsequent pushes.
//  5 Queue holding 5 words, flush_i=1 with fv_i=1 -> next cycle count=0, dv_o=0, pushed word dropped.
//  6 A then P arriving 2 cycles later (before timeout) -> one pair issue {A,P}.
//    A then P arriving after 4 cycles with dready_i=1 -> A issued alone, then P discarded as orphan.

Source files
------------

// File: rtl/rfphoenix_insn_queue.sv
//------------------------------------------------------------------------------
// Module      : rfphoenix_insn_queue
// Description : Fetch-to-decoder instruction queue that fuses each instruction
//               with an immediately following postfix word and drops orphans.
//               Optional statistics counters: define RFPHX_IQ_STATS_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rfphoenix_insn_queue #(
    parameter int                 DEPTH   = 8,
    parameter int                 INSN_W  = 40,
    parameter int                 OPC_W   = 7,
    // Defaults to all-ones; override with rfPhoenixPkg::PFX at integration.
    parameter logic [OPC_W-1:0]   PFX_OPC = {OPC_W{1'b1}},
    parameter int                 LA_TMO  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              fv_i,
    input  logic [INSN_W-1:0] fword_i,
    output logic              fready_o,
    output logic              dv_o,
    output logic [INSN_W-1:0] ir_o,
    output logic [INSN_W-1:0] pfx_o,
    input  logic              dready_i,
    output logic              orphan_o
`ifdef RFPHX_IQ_STATS_EN
   ,output logic [31:0]       stat_issued_o,
    output logic [31:0]       stat_fused_o,
    output logic [15:0]       stat_orphan_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(LA_TMO + 1);

    logic [INSN_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              fready_q, fready_d;
    logic              lone_q, lone_d;

    logic [INSN_W-1:0] head, nxt;
    logic              head_pfx, nxt_pfx, cnt_one, cnt_ge1, cnt_ge2;
    logic              orphan, pair, push;
    logic [1:0]        popn;

    assign head     = mem_q[rd_q];
    assign nxt      = mem_q[rd_q + AW'(1)];
    assign head_pfx = (head[OPC_W-1:0] == PFX_OPC);
    assign nxt_pfx  = (nxt[OPC_W-1:0] == PFX_OPC);
    assign cnt_ge1  = (count_q != '0);
    assign cnt_ge2  = (count_q >= CW'(2));
    assign cnt_one  = (count_q == CW'(1));

    always_comb begin
        dv_o   = 1'b0;
        ir_o   = '0;
        pfx_o  = '0;
        orphan = 1'b0;
        pair   = 1'b0;
        if (cnt_ge1 && head_pfx) begin
            orphan = 1'b1;
        end else if (cnt_ge2) begin
            dv_o = 1'b1;
            ir_o = head;
            // Once a lone issue has been offered it stays lone, even if a postfix lands behind it.
            if (nxt_pfx && !lone_q) begin
                pair  = 1'b1;
                pfx_o = nxt;
            end
        end else if (cnt_one && (tmo_q == TW'(LA_TMO))) begin
            dv_o = 1'b1;
            ir_o = head;
        end
    end

    always_comb begin
        popn = 2'd0;
        if (flush_i)
            popn = 2'd0;
        else if (orphan)
            popn = 2'd1;
        else if (dv_o && dready_i)
            popn = pair ? 2'd2 : 2'd1;

        push    = fv_i && fready_q && !flush_i;
        count_d = count_q + CW'(push) - CW'(popn);
        rd_d    = rd_q + AW'(popn);
        wr_d    = wr_q + AW'(push);
        lone_d  = !flush_i && dv_o && !dready_i && !pair;

        tmo_d = tmo_q;
        if (flush_i || (popn != 2'd0) || !cnt_one || head_pfx)
            tmo_d = '0;
        else if (tmo_q != TW'(LA_TMO))
            tmo_d = tmo_q + TW'(1);

        if (flush_i) begin
            count_d = '0;
            rd_d    = '0;
            wr_d    = '0;
        end
        fready_d = (count_d < CW'(DEPTH));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q     <= '0;
            wr_q     <= '0;
            count_q  <= '0;
            tmo_q    <= '0;
            fready_q <= 1'b0;
            lone_q   <= 1'b0;
        end else begin
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            count_q  <= count_d;
            tmo_q    <= tmo_d;
            fready_q <= fready_d;
            lone_q   <= lone_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem_q[wr_q] <= fword_i;
    end

    assign fready_o = fready_q;
    assign orphan_o = orphan && !flush_i;

`ifdef RFPHX_IQ_STATS_EN
    logic [31:0] issued_q, fused_q;
    logic [15:0] orph_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issued_q <= '0;
            fused_q  <= '0;
            orph_q   <= '0;
        end else begin
            if (dv_o && dready_i && !flush_i) issued_q <= issued_q + 32'd1;
            if (dv_o && dready_i && !flush_i && pair) fused_q <= fused_q + 32'd1;
            if (orphan_o) orph_q <= orph_q + 16'd1;
        end
    end

    assign stat_issued_o = issued_q;
    assign stat_fused_o  = fused_q;
    assign stat_orphan_o = orph_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rfphoenix_insn_queue.sv
//------------------------------------------------------------------------------
// Module      : tb_rfphoenix_insn_queue
// Description : Directed self-checking bench for rfphoenix_insn_queue.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rfphoenix_insn_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, fv, dready;
    logic [39:0] fword;
    logic        fready, dv, orphan;
    logic [39:0] ir, pfx;
`ifdef RFPHX_IQ_STATS_EN
    logic [31:0] st_issued, st_fused;
    logic [15:0] st_orphan;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // ADD opcode 7'h02, ADDI 7'h04, postfix 7'h7F (default PFX_OPC)
    localparam logic [39:0] A_ADD  = 40'h11_2233_4402;
    localparam logic [39:0] B_ADD  = 40'h55_6677_8802;
    localparam logic [39:0] A_ADDI = 40'hAB_CDEF_0104;
    localparam logic [39:0] P_IMM  = 40'h00_0012_34FF;

    always #5 clk = ~clk;

    rfphoenix_insn_queue dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .flush_i  (flush),
        .fv_i     (fv),
        .fword_i  (fword),
        .fready_o (fready),
        .dv_o     (dv),
        .ir_o     (ir),
        .pfx_o    (pfx),
        .dready_i (dready),
        .orphan_o (orphan)
`ifdef RFPHX_IQ_STATS_EN
       ,.stat_issued_o (st_issued),
        .stat_fused_o  (st_fused),
        .stat_orphan_o (st_orphan)
`endif
    );

    function automatic logic [39:0] mkw(input int i);
        return {24'hC0DE00, 8'(i), 8'h02};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; fv = 1'b0; flush = 1'b0; dready = 1'b0; fword = '0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fv = 1'b0; flush = 1'b0; dready = 1'b0; fword = '0;
        tick();
        n_checks++;
        if ({dv, orphan, fready} !== 3'b000 || ir !== '0 || pfx !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: dv=%b orphan=%b fready=%b ir=%h pfx=%h, required all zero",
                     dv, orphan, fready, ir, pfx);
        end
        n_checks++;
        if (dut.count_q !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d required 0", dut.count_q);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (fready !== 1'b1 || dv !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: fready=%b dv=%b, required 1/0", fready, dv);
        end
    endtask

    task automatic test_single_pair();
        int waited;
        dready = 1'b1;
        fv = 1'b1; fword = A_ADD;
        tick();
        fword = B_ADD;
        n_checks++;
        if (dv !== 1'b0) begin
            n_fail++;
            $display("FAIL lone_head_early: dv=%b required 0", dv);
        end
        tick();
        fv = 1'b0;
        n_checks++;
        if (dv !== 1'b1 || ir !== A_ADD || pfx !== '0) begin
            n_fail++;
            $display("FAIL single_A: dv=%b ir=%h pfx=%h, required 1 %h 0", dv, ir, pfx, A_ADD);
        end
        tick();
        waited = 0;
        while (dv !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        n_checks++;
        if (waited != 4 || ir !== B_ADD || pfx !== '0) begin
            n_fail++;
            $display("FAIL timeout_B: waited=%0d ir=%h pfx=%h, required 4 %h 0", waited, ir, pfx, B_ADD);
        end
        tick();
        n_checks++;
        if (dut.count_q !== 4'd0 || dv !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_1: count=%0d dv=%b, required 0 0", dut.count_q, dv);
        end
    endtask

    task automatic test_fused_pair();
        dready = 1'b1;
        fv = 1'b1; fword = A_ADDI;
        tick();
        fword = P_IMM;
        tick();
        fv = 1'b0;
        n_checks++;
        if (dv !== 1'b1 || ir !== A_ADDI || pfx !== P_IMM || dut.count_q !== 4'd2) begin
            n_fail++;
            $display("FAIL pair_issue: dv=%b ir=%h pfx=%h count=%0d, required 1 %h %h 2",
                     dv, ir, pfx, dut.count_q, A_ADDI, P_IMM);
        end
        tick();
        n_checks++;
        if (dut.count_q !== 4'd0 || dv !== 1'b0) begin
            n_fail++;
            $display("FAIL pair_pop2: count=%0d dv=%b, required 0 0", dut.count_q, dv);
        end
    endtask

    task automatic test_orphan();
        do_reset();
        fv = 1'b1; fword = P_IMM;
        tick();
        fv = 1'b0;
        n_checks++;
        if (orphan !== 1'b1 || dv !== 1'b0) begin
            n_fail++;
            $display("FAIL orphan_pulse: orphan=%b dv=%b, required 1 0", orphan, dv);
        end
        tick();
        n_checks++;
        if (orphan !== 1'b0 || dv !== 1'b0 || dut.count_q !== 4'd0) begin
            n_fail++;
            $display("FAIL orphan_after: orphan=%b dv=%b count=%0d, required 0 0 0",
                     orphan, dv, dut.count_q);
        end
`ifdef RFPHX_IQ_STATS_EN
        n_checks++;
        if (st_orphan !== 16'd1) begin
            n_fail++;
            $display("FAIL stat_orphan: got %0d required 1", st_orphan);
        end
`endif
    endtask

    task automatic test_full_wrap();
        int waited;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            fv = 1'b1; fword = mkw(i);
            tick();
        end
        n_checks++;
        if (fready !== 1'b0 || dut.count_q !== 4'd8 || ir !== mkw(0)) begin
            n_fail++;
            $display("FAIL full: fready=%b count=%0d ir=%h, required 0 8 %h",
                     fready, dut.count_q, ir, mkw(0));
        end
        dready = 1'b1; fword = mkw(8);
        tick();
        n_checks++;
        if (dut.count_q !== 4'd7 || fready !== 1'b1 || ir !== mkw(1)) begin
            n_fail++;
            $display("FAIL full_refuse: count=%0d fready=%b ir=%h, required 7 1 %h",
                     dut.count_q, fready, ir, mkw(1));
        end
        dready = 1'b0;
        tick();
        fv = 1'b0;
        n_checks++;
        if (dut.count_q !== 4'd8 || fready !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_push: count=%0d fready=%b, required 8 0", dut.count_q, fready);
        end
        dready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            n_checks++;
            if (dv !== 1'b1 || ir !== mkw(i)) begin
                n_fail++;
                $display("FAIL drain_%0d: dv=%b ir=%h, required 1 %h", i, dv, ir, mkw(i));
            end
            tick();
        end
        waited = 0;
        while (dv !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        n_checks++;
        if (waited != 4 || ir !== mkw(8)) begin
            n_fail++;
            $display("FAIL wrap_last: waited=%0d ir=%h, required 4 %h", waited, ir, mkw(8));
        end
        tick();
        dready = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            fv = 1'b1; fword = mkw(16 + i);
            tick();
        end
        n_checks++;
        if (dut.count_q !== 4'd5) begin
            n_fail++;
            $display("FAIL flush_fill: count=%0d required 5", dut.count_q);
        end
        flush = 1'b1; fword = mkw(99);
        tick();
        flush = 1'b0; fv = 1'b0;
        n_checks++;
        if (dut.count_q !== 4'd0 || dv !== 1'b0 || fready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush: count=%0d dv=%b fready=%b, required 0 0 1",
                     dut.count_q, dv, fready);
        end
        tick();
        n_checks++;
        if (dv !== 1'b0 || dut.count_q !== 4'd0) begin
            n_fail++;
            $display("FAIL flush_drop: dv=%b count=%0d, required 0 0", dv, dut.count_q);
        end
    endtask

    task automatic test_lookahead();
        do_reset();
        dready = 1'b1;
        fv = 1'b1; fword = A_ADDI;
        tick();
        fv = 1'b0;
        tick();
        fv = 1'b1; fword = P_IMM;
        tick();
        fv = 1'b0;
        n_checks++;
        if (dv !== 1'b1 || ir !== A_ADDI || pfx !== P_IMM) begin
            n_fail++;
            $display("FAIL late_pair: dv=%b ir=%h pfx=%h, required 1 %h %h", dv, ir, pfx, A_ADDI, P_IMM);
        end
        tick();
        fv = 1'b1; fword = A_ADDI;
        tick();
        fv = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        fv = 1'b1; fword = P_IMM;
        n_checks++;
        if (dv !== 1'b1 || ir !== A_ADDI || pfx !== '0) begin
            n_fail++;
            $display("FAIL timeout_alone: dv=%b ir=%h pfx=%h, required 1 %h 0", dv, ir, pfx, A_ADDI);
        end
        tick();
        fv = 1'b0;
        n_checks++;
        if (orphan !== 1'b1 || dv !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_orphan: orphan=%b dv=%b, required 1 0", orphan, dv);
        end
        tick();
    endtask

    task automatic test_lone_hold();
        dready = 1'b0;
        fv = 1'b1; fword = B_ADD;
        tick();
        fv = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        fv = 1'b1; fword = P_IMM;
        tick();
        fv = 1'b0;
        n_checks++;
        if (dv !== 1'b1 || ir !== B_ADD || pfx !== '0 || dut.count_q !== 4'd2) begin
            n_fail++;
            $display("FAIL lone_hold: dv=%b ir=%h pfx=%h count=%0d, required 1 %h 0 2",
                     dv, ir, pfx, dut.count_q, B_ADD);
        end
        dready = 1'b1;
        tick();
        n_checks++;
        if (orphan !== 1'b1 || dv !== 1'b0) begin
            n_fail++;
            $display("FAIL lone_hold_orphan: orphan=%b dv=%b, required 1 0", orphan, dv);
        end
        tick();
        dready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_pair();
        test_fused_pair();
        test_orphan();
        test_full_wrap();
        test_flush();
        test_lookahead();
        test_lone_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
